// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the LSU bus sequencer slice.
//   - size encodings used on req_size (3 is handled as a word)
//   - one-hot FSM state encoding for lsu_bus_ctrl
//   - misalignment predicate and byte-lane offset helper
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_RD   = 4'b0010,
    ST_WR   = 4'b0100,
    ST_RESP = 4'b1000
  } state_e;

  // True when the access cannot be served by a single naturally aligned lane group.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

  // Byte offset of the access inside the bus word. Halves snap to their
  // containing half-word and words to lane 0, so an unchecked misaligned
  // access still lands on a legal lane group.
  function automatic logic [1:0] lane_off(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [1:0] off;
    case (size)
      SZ_B:    off = addr_lo;
      SZ_H:    off = {addr_lo[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// lsu_bus_ctrl_if: request/response and d_r*/d_w* arbiter signals of the LSU
// bus sequencer.
//   slave  : view of lsu_bus_ctrl (takes requests, drives the arbiter port)
//   master : view of the surrounding logic (execute stage + arbiter)
// Parameter ADDR_W: request and bus address width.
interface lsu_bus_ctrl_if #(parameter int ADDR_W = 32);

  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              d_rvalid;
  logic              d_rready;
  logic [ADDR_W-1:0] d_raddr;
  logic [31:0]       d_rdata;
  logic              d_wvalid;
  logic              d_wready;
  logic [ADDR_W-1:0] d_waddr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wstrb;

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    input  d_rready, d_rdata, d_wready,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output d_rvalid, d_raddr, d_wvalid, d_waddr, d_wdata, d_wstrb
  );

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    output d_rready, d_rdata, d_wready,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  d_rvalid, d_raddr, d_wvalid, d_waddr, d_wdata, d_wstrb
  );

endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane logic for the LSU bus sequencer.
//   addr_lo     in  2   low address bits of the latched request
//   size        in  2   access size (SZ_B/SZ_H/SZ_W, 3 = word)
//   wdata       in  32  right-aligned store data
//   is_unsigned in  1   zero-extend loads
//   rdata       in  32  raw bus read data
//   wdata_sh    out 32  store data shifted onto its lanes
//   wstrb       out 4   byte strobes
//   rdata_ext   out 32  load data extracted and extended
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_sh,
  output logic [3:0]  wstrb,
  output logic [31:0] rdata_ext
);

  logic [1:0]  off_s;
  logic [4:0]  shamt_s;
  logic [31:0] lane_s;
  logic        sx_b_s;
  logic        sx_h_s;

  assign off_s    = lane_off(size, addr_lo);
  assign shamt_s  = {off_s, 3'b000};
  assign wdata_sh = wdata << shamt_s;
  assign lane_s   = rdata >> shamt_s;
  assign sx_b_s   = ~is_unsigned & lane_s[7];
  assign sx_h_s   = ~is_unsigned & lane_s[15];

  // Strobe generation and load truncation/extension by access size.
  always_comb begin
    wstrb     = 4'b1111;
    rdata_ext = rdata;
    case (size)
      SZ_B: begin
        wstrb     = 4'b0001 << off_s;
        rdata_ext = {{24{sx_b_s}}, lane_s[7:0]};
      end
      SZ_H: begin
        wstrb     = 4'b0011 << off_s;
        rdata_ext = {{16{sx_h_s}}, lane_s[15:0]};
      end
      default: begin
        wstrb     = 4'b1111;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: single-outstanding load/store sequencer between the LSU
// execute stage and the LSU read/write ports of the IFU/LSU AXI arbiter.
//   clock  in  clock
//   reset  in  synchronous, active-high reset
//   bus    lsu_bus_ctrl_if.slave: req_*/resp_* request side, d_r*/d_w* arbiter side
// Parameters:
//   ADDR_W          request/bus address width
//   ALIGN_BUS_ADDR  1: bus addresses have bits [1:0] cleared; 0: pass through
// Build option LSU_MISALIGN_CHECK_EN: misaligned halves/words skip the bus and
// complete immediately with resp_err=1. Without it resp_err is tied low.
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter bit ALIGN_BUS_ADDR = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  lsu_bus_ctrl_if.slave bus
);

  state_e            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic              req_ready_r;
  logic              d_rvalid_r;
  logic              d_wvalid_r;
  logic              resp_valid_r;
  logic [31:0]       resp_rdata_r;
  logic              resp_err_r;

  logic              misalign_s;
  logic [ADDR_W-1:0] bus_addr_s;
  logic [31:0]       wdata_sh_s;
  logic [3:0]        wstrb_s;
  logic [31:0]       rdata_ext_s;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_s = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  assign bus_addr_s = ALIGN_BUS_ADDR ? {addr_r[ADDR_W-1:2], 2'b00} : addr_r;

  lsu_lane_align u_lane (
    .addr_lo     (addr_r[1:0]),
    .size        (size_r),
    .wdata       (wdata_r),
    .is_unsigned (uns_r),
    .rdata       (bus.d_rdata),
    .wdata_sh    (wdata_sh_s),
    .wstrb       (wstrb_s),
    .rdata_ext   (rdata_ext_s)
  );

  // Sequencer FSM; every handshake output is a flop updated with the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      addr_r       <= '0;
      wdata_r      <= 32'h0000_0000;
      size_r       <= SZ_B;
      uns_r        <= 1'b0;
      req_ready_r  <= 1'b1;
      d_rvalid_r   <= 1'b0;
      d_wvalid_r   <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid) begin
            addr_r      <= bus.req_addr;
            wdata_r     <= bus.req_wdata;
            size_r      <= bus.req_size;
            uns_r       <= bus.req_unsigned;
            req_ready_r <= 1'b0;
            if (misalign_s) begin
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'h0000_0000;
            end else if (bus.req_wen) begin
              state_r    <= ST_WR;
              d_wvalid_r <= 1'b1;
            end else begin
              state_r    <= ST_RD;
              d_rvalid_r <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (bus.d_rready) begin
            state_r      <= ST_RESP;
            d_rvalid_r   <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_rdata_r <= rdata_ext_s;
            resp_err_r   <= 1'b0;
          end
        end
        ST_WR: begin
          if (bus.d_wready) begin
            state_r      <= ST_RESP;
            d_wvalid_r   <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
          end
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          resp_valid_r <= 1'b0;
          req_ready_r  <= 1'b1;
        end
        default: begin
          // Illegal one-hot pattern: fall back to a quiet idle.
          state_r      <= ST_IDLE;
          req_ready_r  <= 1'b1;
          d_rvalid_r   <= 1'b0;
          d_wvalid_r   <= 1'b0;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.d_rvalid   = d_rvalid_r;
  assign bus.d_raddr    = bus_addr_s;
  assign bus.d_wvalid   = d_wvalid_r;
  assign bus.d_waddr    = bus_addr_s;
  assign bus.d_wdata    = wdata_sh_s;
  assign bus.d_wstrb    = wstrb_s;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl: directed self-checking bench for lsu_bus_ctrl.
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point, i.e. they show the state after that edge.
module tb_lsu_bus_ctrl;

  import lsu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   rv_eps = 0;
  logic prev_rv = 1'b0;

  lsu_bus_ctrl_if #(.ADDR_W(32)) bus ();

  lsu_bus_ctrl #(.ADDR_W(32), .ALIGN_BUS_ADDR(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and count rising edges of d_rvalid.
  task automatic tick();
    @(posedge clock);
    #1;
    if (bus.d_rvalid && !prev_rv) rv_eps++;
    prev_rv = bus.d_rvalid;
  endtask

  task automatic load_chk(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] rdata, input int delay,
                          input logic [31:0] exp);
    bus.req_valid    = 1'b1;
    bus.req_wen      = 1'b0;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    tick();
    bus.req_valid = 1'b0;
    chk({tag, "_rvalid"}, {31'd0, bus.d_rvalid}, 32'd1);
    chk({tag, "_wvalid"}, {31'd0, bus.d_wvalid}, 32'd0);
    chk({tag, "_raddr"}, bus.d_raddr, {addr[31:2], 2'b00});
    repeat (delay) tick();
    chk({tag, "_rvalid_hold"}, {31'd0, bus.d_rvalid}, 32'd1);
    bus.d_rready = 1'b1;
    bus.d_rdata  = rdata;
    tick();
    bus.d_rready = 1'b0;
    bus.d_rdata  = 32'h0BAD_0BAD;
    chk({tag, "_rvalid_drop"}, {31'd0, bus.d_rvalid}, 32'd0);
    chk({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
    chk({tag, "_rdata"}, bus.resp_rdata, exp);
    chk({tag, "_err"}, {31'd0, bus.resp_err}, 32'd0);
    chk({tag, "_ready_busy"}, {31'd0, bus.req_ready}, 32'd0);
    tick();
    chk({tag, "_resp_pulse"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic store_chk(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input int delay, input logic [31:0] e_addr,
                           input logic [31:0] e_data, input logic [3:0] e_strb);
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b1;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_size  = size;
    tick();
    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
    bus.req_wdata = 32'h0000_0000;
    chk({tag, "_wvalid"}, {31'd0, bus.d_wvalid}, 32'd1);
    chk({tag, "_rvalid"}, {31'd0, bus.d_rvalid}, 32'd0);
    chk({tag, "_waddr"}, bus.d_waddr, e_addr);
    chk({tag, "_wdata"}, bus.d_wdata, e_data);
    chk({tag, "_wstrb"}, {28'd0, bus.d_wstrb}, {28'd0, e_strb});
    repeat (delay) tick();
    chk({tag, "_wvalid_hold"}, {31'd0, bus.d_wvalid}, 32'd1);
    chk({tag, "_wdata_stable"}, bus.d_wdata, e_data);
    bus.d_wready = 1'b1;
    tick();
    bus.d_wready = 1'b0;
    chk({tag, "_wvalid_drop"}, {31'd0, bus.d_wvalid}, 32'd0);
    chk({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
    chk({tag, "_rdata_zero"}, bus.resp_rdata, 32'h0000_0000);
    chk({tag, "_err"}, {31'd0, bus.resp_err}, 32'd0);
    tick();
    chk({tag, "_resp_pulse"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_wen      = 1'b0;
    bus.req_addr     = 32'h0000_0000;
    bus.req_wdata    = 32'h0000_0000;
    bus.req_size     = SZ_B;
    bus.req_unsigned = 1'b0;
    bus.d_rready     = 1'b0;
    bus.d_rdata      = 32'h0000_0000;
    bus.d_wready     = 1'b0;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
    chk("rst_wvalid", {31'd0, bus.d_wvalid}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0000_0000);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);

    // Signed byte load leaves non-zero resp_rdata before the first store
    load_chk("ld_b_s", 32'h8000_0000, SZ_B, 1'b0, 32'h0000_0080, 1, 32'hFFFF_FF80);

    // Stores: byte at lane 3, half at lane 2, word, size 3 as word
    store_chk("st_b3", 32'h8000_0003, 32'h0000_00AB, SZ_B, 2,
              32'h8000_0000, 32'hAB00_0000, 4'b1000);
    store_chk("st_h2", 32'h8000_0002, 32'h0000_BEEF, SZ_H, 0,
              32'h8000_0000, 32'hBEEF_0000, 4'b1100);
    store_chk("st_w", 32'h8000_0004, 32'h1234_5678, SZ_W, 1,
              32'h8000_0004, 32'h1234_5678, 4'b1111);
    store_chk("st_sz3", 32'h8000_0008, 32'hCAFE_F00D, 2'd3, 0,
              32'h8000_0008, 32'hCAFE_F00D, 4'b1111);

    // Half loads signed/unsigned, unsigned byte lane 1, word ignores unsigned
    load_chk("ld_h_s", 32'h8000_0002, SZ_H, 1'b0, 32'h8001_1234, 0, 32'hFFFF_8001);
    load_chk("ld_h_u", 32'h8000_0002, SZ_H, 1'b1, 32'h8001_1234, 2, 32'h0000_8001);
    load_chk("ld_b_u", 32'h8000_0001, SZ_B, 1'b1, 32'h1234_56F0, 0, 32'h0000_0056);
    load_chk("ld_w_u", 32'h8000_000C, SZ_W, 1'b1, 32'hF123_4567, 0, 32'hF123_4567);

    // Two back-to-back loads with req_valid held high and d_rready delayed
    rv_eps            = 0;
    bus.req_valid     = 1'b1;
    bus.req_wen       = 1'b0;
    bus.req_addr      = 32'h8000_0010;
    bus.req_size      = SZ_W;
    bus.req_unsigned  = 1'b0;
    tick();
    repeat (5) tick();
    chk("b2b_a_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
    chk("b2b_a_ready", {31'd0, bus.req_ready}, 32'd0);
    bus.d_rready = 1'b1;
    bus.d_rdata  = 32'h1111_1111;
    tick();
    bus.d_rready = 1'b0;
    chk("b2b_a_resp", {31'd0, bus.resp_valid}, 32'd1);
    chk("b2b_a_rdata", bus.resp_rdata, 32'h1111_1111);
    chk("b2b_a_ready_resp", {31'd0, bus.req_ready}, 32'd0);
    tick();
    chk("b2b_ready2", {31'd0, bus.req_ready}, 32'd1);
    chk("b2b_rvalid_idle", {31'd0, bus.d_rvalid}, 32'd0);
    bus.req_addr = 32'h8000_0014;
    tick();
    bus.req_valid = 1'b0;
    chk("b2b_b_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
    chk("b2b_b_raddr", bus.d_raddr, 32'h8000_0014);
    repeat (5) tick();
    bus.d_rready = 1'b1;
    bus.d_rdata  = 32'h2222_2222;
    tick();
    bus.d_rready = 1'b0;
    chk("b2b_b_resp", {31'd0, bus.resp_valid}, 32'd1);
    chk("b2b_b_rdata", bus.resp_rdata, 32'h2222_2222);
    tick();
    chk("b2b_episodes", rv_eps, 32'd2);

    // Misaligned word load
`ifdef LSU_MISALIGN_CHECK_EN
    rv_eps           = 0;
    bus.req_valid    = 1'b1;
    bus.req_wen      = 1'b0;
    bus.req_addr     = 32'h8000_0002;
    bus.req_size     = SZ_W;
    bus.req_unsigned = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    chk("mis_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("mis_resp_err", {31'd0, bus.resp_err}, 32'd1);
    chk("mis_rdata", bus.resp_rdata, 32'h0000_0000);
    tick();
    chk("mis_resp_pulse", {31'd0, bus.resp_valid}, 32'd0);
    chk("mis_no_bus", rv_eps, 32'd0);
`else
    load_chk("mis_w", 32'h8000_0002, SZ_W, 1'b0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
`endif

    // Reset while a read is pending
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b0;
    bus.req_addr  = 32'h8000_0020;
    bus.req_size  = SZ_W;
    tick();
    bus.req_valid = 1'b0;
    chk("rstrd_rvalid", {31'd0, bus.d_rvalid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstrd_rvalid_off", {31'd0, bus.d_rvalid}, 32'd0);
    chk("rstrd_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rstrd_req_ready", {31'd0, bus.req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Load/store sequencer between the LSU execute stage and the LSU-side read/write ports of the IFU/LSU AXI arbiter (d_r*/d_w*).
- Accepts one memory request at a time and issues word-aligned bus accesses, with byte-lane shifting and strobe generation.
- Returns sign/zero-extended load data or a store completion as a single-cycle response.
- At most one transaction in flight; reads and writes are never issued concurrently.

Parameters:
ADDR_W, 32, request/bus address width
ALIGN_BUS_ADDR, 1, 1: d_raddr/d_waddr have bits [1:0] forced to 0; 0: full request address passed through

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when both high
req_wen  in  1  1 store, 0 load
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
req_size  in  2  0 byte, 1 half, 2 word, 3 treated as word
req_unsigned  in  1  zero-extend load
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data (0 for stores)
resp_err  out  1  misaligned-access error (see Optional Feature)
d_rvalid  out  1  read request to arbiter
d_rready  in  1  read data valid this cycle
d_raddr  out  ADDR_W  read address
d_rdata  in  32  read data
d_wvalid  out  1  write request to arbiter
d_wready  in  1  write response received this cycle
d_waddr  out  ADDR_W  write address
d_wdata  out  32  lane-shifted write data
d_wstrb  out  4  byte strobes

Behaviour:
- Reset values: state IDLE, req_ready=1, d_rvalid=0, d_wvalid=0, resp_valid=0, resp_rdata=0, resp_err=0.
- One-hot FSM: IDLE, RD, WR, RESP.
  - IDLE: req_ready=1. On req_valid, latch addr, wdata, size, unsigned, wen, then go to WR if wen, else RD.
  - RD: d_rvalid=1. On d_rready, capture the extended d_rdata into resp_rdata and go to RESP.
  - WR: d_wvalid=1. On d_wready, go to RESP; resp_rdata=0.
  - RESP: resp_valid=1 for exactly one cycle, no backpressure, then IDLE.
- req_ready=0 in RD, WR and RESP. A new request is accepted no earlier than the cycle after RESP.
- d_rvalid and d_wvalid are decoded from the state register only, never combinationally from inputs.
  - They stay high until the respective ready and drop the following cycle, so the arbiter returns to idle without re-triggering.
- Bus address, data and strobe are driven from the latched registers and stay stable throughout RD/WR.
- Lane logic, with off = addr[1:0]:
  - d_wdata = wdata << 8*off.
  - d_wstrb: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
  - Load: lane = d_rdata >> 8*off, truncated to size, sign-extended unless unsigned. Word loads ignore unsigned.
- Latency: resp_valid asserts exactly one cycle after the d_rready/d_wready cycle.
- Reset in any state returns to IDLE next edge and deasserts all valids. The arbiter shares the same reset.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined:
  - A half with addr[0]=1, or a word with addr[1:0]!=0, performs no bus access.
  - IDLE goes directly to RESP with resp_err=1 and resp_rdata=0.
  - resp_err=0 for all other requests.
- Undefined:
  - resp_err is tied 0 and all requests go to the bus.
  - Half uses off={addr[1],0}; word uses off=0.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_B=2'd0, SZ_H=2'd1, SZ_W=2'd2;
  - the one-hot state constants;
  - the misalignment predicate as a function.
- Natural sub-module: lsu_lane_align, purely combinational, covering wstrb/wdata shift and load extract/extend.
- The FSM stays in lsu_bus_ctrl.

Test Plan:
- Store byte 0xAB at 0x8000_0003 -> d_waddr=0x8000_0000, d_wstrb=4'b1000, d_wdata=0xAB00_0000; d_wvalid held until d_wready; resp_valid one cycle later, resp_rdata=0.
- Signed half load at 0x8000_0002, d_rdata=0x8001_1234 -> resp_rdata=0xFFFF_8001; same with req_unsigned=1 -> 0x0000_8001.
- Unsigned byte load at 0x8000_0001, d_rdata=0x1234_56F0 -> resp_rdata=0x0000_0056; d_rvalid low the cycle after d_rready.
- req_valid held high for two loads, d_rready delayed 5 cycles -> exactly one d_rvalid episode each; second req_ready one cycle after the first resp_valid.
- With LSU_MISALIGN_CHECK_EN, word load at 0x8000_0002 -> d_rvalid never asserted; resp_valid and resp_err=1 one cycle after accept. Without the macro -> bus read at 0x8000_0000, resp_err=0.
- Reset asserted while in RD with d_rready pending -> next cycle d_rvalid=0, resp_valid=0, req_ready=1.
